// File: rtl/inert_serf_pkg.sv
// Shared definitions for the inert_serf SPI register slave.
//   - Register map addresses (7-bit SPI address space)
//   - Default WHO_AM_I identity byte
//   - Frame geometry constants for the bit counter
//   - Frame FSM state encoding
package inert_serf_pkg;

  localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
  localparam logic [6:0] ADDR_CFG      = 7'h10;
  localparam logic [6:0] ADDR_YAW_L    = 7'h26;
  localparam logic [6:0] ADDR_YAW_H    = 7'h27;

  localparam logic [7:0] WHO_AM_I_DEFAULT = 8'h6A;

  // Bit counter counts SCLK rises in a frame and saturates at FRAME_BITS.
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CMD_BITS   = 5'd8;
  // Counter value seen on the rise that completes the command byte.
  localparam logic [4:0] CMD_LAST   = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/serf_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus single-cycle
// rise/fall strobes derived from the synchronized level.
// A pin edge shows up as a strobe acted on at the third clk edge.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   din   : asynchronous input pin
//   rise  : one-clk strobe, synchronized 0->1
//   fall  : one-clk strobe, synchronized 1->0
// RST_VAL is the idle level of the pin; all three flops reset to it so
// no spurious edge is produced when reset is released with the pin idle.
module serf_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/inert_serf.sv
// SPI register slave exposing a yaw-rate sample, a config register and a
// data-ready interrupt. SPI mode 3 (SCLK idles high, sampled on rise),
// 16-bit frames: bit15 R/W (1 = read), bits14:8 address, bits7:0 data.
//
// Ports:
//   clk     : system clock, all state on rising edge
//   RST     : asynchronous active-high reset
//   SS_n    : SPI select, active low (asynchronous to clk)
//   SCLK    : SPI clock from the monarch (asynchronous to clk)
//   MOSI    : serial command/data in, MSB first
//   MISO    : serial read data out, MSB first, 0 while SS_n is high
//   INT     : yaw data-ready interrupt, active high
//   yaw_in  : new yaw-rate sample
//   yaw_vld : one-clk strobe qualifying yaw_in
//   cfg     : current contents of CFG (0x10)
//
// Build option: define INERT_SERF_INT_EN to implement INT_CTRL (0x0D) and
// the interrupt. Without it INT is tied low and INT_CTRL reads 0x00.
module inert_serf
  import inert_serf_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I = WHO_AM_I_DEFAULT
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] yaw_in,
  input  logic        yaw_vld,
  output logic [7:0]  cfg
);

  logic        ss_rise;
  logic        ss_fall;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        mosi_meta;
  logic        mosi_sync;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [15:0] rx;
  logic [7:0]  tx;
  logic        cmd_rd;
  logic [6:0]  cmd_addr;

  logic [7:0]  cfg_q;
  logic [15:0] yaw;
  logic [15:0] yaw_hold;
  logic        yaw_pend;
  logic [7:0]  int_ctrl;
  logic        int_q;

  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        yaw_block;
  logic        yaw_cap;
  logic [15:0] yaw_cap_val;
  logic        frame_done;
  logic        wr_en;
  logic [6:0]  wr_addr;

  serf_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst  (RST),
    .din  (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  serf_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (RST),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // MOSI only needs a level; it is stable around SCLK rise, and its
  // synchronizer has the same depth as the one feeding sclk_rise.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  // On the 8th rise the command byte is {rx[6:0], mosi_sync}, so the
  // address is decoded before the shift register has absorbed it.
  always_comb begin
    rd_addr = {rx[5:0], mosi_sync};
    case (rd_addr)
      ADDR_INT_CTRL: rd_data = int_ctrl;
      ADDR_WHO_AM_I: rd_data = WHO_AM_I;
      ADDR_CFG:      rd_data = cfg_q;
      ADDR_YAW_L:    rd_data = yaw[7:0];
      ADDR_YAW_H:    rd_data = yaw[15:8];
      default:       rd_data = 8'h00;
    endcase
  end

  // A frame only counts if all 16 bits arrived before SS_n rose; anything
  // else is dropped without side effects.
  always_comb begin
    frame_done = ss_rise && (state != ST_IDLE) && (bit_cnt == FRAME_BITS);
    wr_en      = frame_done && !rx[15];
    wr_addr    = rx[14:8];
  end

  // Hold off yaw updates while a YAW byte is being shifted out so a read
  // of L then H never mixes two samples; the newest sample is parked.
  always_comb begin
    yaw_block   = (state == ST_DATA) && cmd_rd &&
                  ((cmd_addr == ADDR_YAW_L) || (cmd_addr == ADDR_YAW_H));
    yaw_cap     = !yaw_block && (yaw_vld || yaw_pend);
    yaw_cap_val = yaw_vld ? yaw_in : yaw_hold;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      bit_cnt  <= 5'd0;
      rx       <= 16'h0000;
      tx       <= 8'h00;
      cmd_rd   <= 1'b0;
      cmd_addr <= 7'h00;
    end else if (ss_rise) begin
      state <= ST_IDLE;
    end else if (ss_fall) begin
      state   <= ST_CMD;
      bit_cnt <= 5'd0;
      cmd_rd  <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (sclk_rise) begin
        rx <= {rx[14:0], mosi_sync};
        if (bit_cnt != FRAME_BITS) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
        if (bit_cnt == CMD_LAST) begin
          state    <= ST_DATA;
          cmd_rd   <= rx[6];
          cmd_addr <= rd_addr;
          tx       <= rx[6] ? rd_data : 8'h00;
        end
      end else if (sclk_fall && (state == ST_DATA) &&
                   (bit_cnt > CMD_BITS) && (bit_cnt < FRAME_BITS)) begin
        // Falls after rises 9..15: bit 7 stays on MISO through rise 9,
        // then one new bit per fall, bit 0 lands in time for rise 16.
        tx <= {tx[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cfg_q    <= 8'h00;
      yaw      <= 16'h0000;
      yaw_hold <= 16'h0000;
      yaw_pend <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == ADDR_CFG)) begin
        cfg_q <= rx[7:0];
      end
      if (yaw_cap) begin
        yaw <= yaw_cap_val;
      end
      if (yaw_block && yaw_vld) begin
        yaw_hold <= yaw_in;
        yaw_pend <= 1'b1;
      end else if (yaw_cap) begin
        yaw_pend <= 1'b0;
      end
    end
  end

`ifdef INERT_SERF_INT_EN
  logic rd_clr;

  assign rd_clr = frame_done && rx[15] && (rx[14:8] == ADDR_YAW_H);

  // Set has priority over clear; disabling the enable leaves a pending
  // interrupt in place until YAW_H is read.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      int_ctrl <= 8'h00;
      int_q    <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == ADDR_INT_CTRL)) begin
        int_ctrl <= rx[7:0];
      end
      if (yaw_cap && int_ctrl[1]) begin
        int_q <= 1'b1;
      end else if (rd_clr) begin
        int_q <= 1'b0;
      end
    end
  end
`else
  assign int_ctrl = 8'h00;
  assign int_q    = 1'b0;
`endif

  // Gated by the raw pin so MISO drops the moment the monarch deselects.
  assign MISO = ~SS_n & tx[7];
  assign INT  = int_q;
  assign cfg  = cfg_q;

endmodule

// File: tb/tb_inert_serf.sv
module tb_inert_serf;

`ifdef INERT_SERF_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk;
  logic        RST;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        INT;
  logic [15:0] yaw_in;
  logic        yaw_vld;
  logic [7:0]  cfg;

  int checks = 0;
  int errors = 0;

  inert_serf dut (
    .clk     (clk),
    .RST     (RST),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .INT     (INT),
    .yaw_in  (yaw_in),
    .yaw_vld (yaw_vld),
    .cfg     (cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    bit          is_rd;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_cfg;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // SCLK half period is 8 clks, comfortably above the 3-clk sync latency.
  task automatic spi_frame(input logic [15:0] w, input int nbits, input bit raise_ss,
                           input int yaw_at, input logic [15:0] yaw_val,
                           output logic [7:0] rb);
    rb = 8'h00;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      if (i == yaw_at) begin
        yaw_in  = yaw_val;
        yaw_vld = 1'b1;
        @(negedge clk);
        yaw_vld = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      if (i >= 8) rb[15-i] = MISO;
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    if (raise_ss) begin
      SS_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic pulse_yaw(input logic [15:0] v);
    yaw_in  = v;
    yaw_vld = 1'b1;
    @(negedge clk);
    yaw_vld = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_check(input string name, input logic [15:0] w, input logic [7:0] exp);
    logic [7:0] rb;
    spi_frame(w, 16, 1'b1, -1, 16'h0000, rb);
    check(name, {8'h00, rb}, {8'h00, exp});
  endtask

  initial begin
    logic [7:0] rb;

    vecs[0]  = '{16'h8F00, 1'b1, 8'h6A, 8'h00};
    vecs[1]  = '{16'h1055, 1'b0, 8'h00, 8'h55};
    vecs[2]  = '{16'h9000, 1'b1, 8'h55, 8'h55};
    vecs[3]  = '{16'h0F12, 1'b0, 8'h00, 8'h55};
    vecs[4]  = '{16'h8F00, 1'b1, 8'h6A, 8'h55};
    vecs[5]  = '{16'h2033, 1'b0, 8'h00, 8'h55};
    vecs[6]  = '{16'hA000, 1'b1, 8'h00, 8'h55};
    vecs[7]  = '{16'h8100, 1'b1, 8'h00, 8'h55};
    vecs[8]  = '{16'h0D02, 1'b0, 8'h00, 8'h55};
    vecs[9]  = '{16'h8D00, 1'b1, (INT_EN ? 8'h02 : 8'h00), 8'h55};
    vecs[10] = '{16'hA600, 1'b1, 8'h00, 8'h55};
    vecs[11] = '{16'h10AA, 1'b0, 8'h00, 8'hAA};
    vecs[12] = '{16'h9000, 1'b1, 8'hAA, 8'hAA};

    RST = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    yaw_in = 16'h0000; yaw_vld = 1'b0;
    repeat (4) @(negedge clk);
    RST = 1'b0;
    repeat (4) @(negedge clk);
    check("reset MISO", {15'd0, MISO}, 16'd0);
    check("reset INT", {15'd0, INT}, 16'd0);
    check("reset cfg", {8'h00, cfg}, 16'h0000);

    for (int k = 0; k < 13; k++) begin
      spi_frame(vecs[k].frame, 16, 1'b1, -1, 16'h0000, rb);
      if (vecs[k].is_rd) check($sformatf("vec%0d rdata", k), {8'h00, rb}, {8'h00, vecs[k].exp_rd});
      check($sformatf("vec%0d cfg", k), {8'h00, cfg}, {8'h00, vecs[k].exp_cfg});
      check($sformatf("vec%0d INT", k), {15'd0, INT}, 16'd0);
    end

    // Yaw capture, interrupt set, read L keeps INT, read H clears it.
    pulse_yaw(16'h1234);
    check("yaw INT set", {15'd0, INT}, {15'd0, INT_EN});
    read_check("yaw_l 34", 16'hA600, 8'h34);
    check("INT after yaw_l", {15'd0, INT}, {15'd0, INT_EN});
    read_check("yaw_h 12", 16'hA700, 8'h12);
    check("INT cleared by yaw_h", {15'd0, INT}, 16'd0);

    // New sample arriving mid-read of YAW_H is deferred to after SS_n rise.
    spi_frame(16'hA700, 16, 1'b0, 10, 16'hBEEF, rb);
    check("deferred yaw old byte", {8'h00, rb}, 16'h0012);
    check("INT held during DATA", {15'd0, INT}, 16'd0);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    check("INT after deferred capture", {15'd0, INT}, {15'd0, INT_EN});
    read_check("yaw_l EF", 16'hA600, 8'hEF);
    check("INT after yaw_l EF", {15'd0, INT}, {15'd0, INT_EN});
    read_check("yaw_h BE", 16'hA700, 8'hBE);
    check("INT cleared after BE", {15'd0, INT}, 16'd0);

    // Reset in the middle of a read of CFG.
    pulse_yaw(16'h0001);
    check("INT before RST", {15'd0, INT}, {15'd0, INT_EN});
    spi_frame(16'h9000, 9, 1'b0, -1, 16'h0000, rb);
    check("MISO mid-read", {15'd0, MISO}, 16'd1);
    RST = 1'b1;
    repeat (2) @(negedge clk);
    check("RST MISO", {15'd0, MISO}, 16'd0);
    check("RST INT", {15'd0, INT}, 16'd0);
    check("RST cfg", {8'h00, cfg}, 16'h0000);
    RST = 1'b0;
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    read_check("post-RST cfg", 16'h9000, 8'h00);
    read_check("post-RST yaw_l", 16'hA600, 8'h00);
    read_check("post-RST yaw_h", 16'hA700, 8'h00);
    read_check("post-RST int_ctrl", 16'h8D00, 8'h00);
    read_check("post-RST who", 16'h8F00, 8'h6A);

    // Aborted write after 12 rises, then a full frame.
    spi_frame(16'h10AA, 12, 1'b1, -1, 16'h0000, rb);
    check("abort cfg", {8'h00, cfg}, 16'h0000);
    spi_frame(16'h1055, 16, 1'b1, -1, 16'h0000, rb);
    check("after abort cfg", {8'h00, cfg}, 16'h0055);
    read_check("after abort read", 16'h9000, 8'h55);
    check("final INT", {15'd0, INT}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inert_serf.md
INERT_SERF -- requirements
Module: inert_serf

Interface
REQ-001 Parameter WHO_AM_I, default 8'h6A, constant returned on read of address 0x0F.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 SS_n  input  1  SPI select, active low, asynchronous to clk.
REQ-005 SCLK  input  1  SPI clock from monarch; idles high; MOSI changes on fall, sampled on rise.
REQ-006 MOSI  input  1  serial command/data, MSB first.
REQ-007 MISO  output  1  serial read data, MSB first; 0 when SS_n high.
REQ-008 INT  output  1  data-ready interrupt, active high.
REQ-009 yaw_in  input  16  new yaw-rate sample.
REQ-010 yaw_vld  input  1  one-clk strobe, yaw_in valid.
REQ-011 cfg  output  8  current contents of register 0x10.

Function
REQ-012 SS_n, SCLK, MOSI SHALL each pass a 2-flop synchronizer; SCLK and SS_n edges detected from synchronized values (pin edge to internal event: 3 clk).
REQ-013 Frame = 16 bits: bit15 R/W (1 = read), bits14:8 address, bits7:0 write data (ignored on read).
REQ-014 FSM states IDLE, CMD, DATA; SS_n fall: IDLE->CMD, bit counter cleared; 8th SCLK rise: CMD->DATA; SS_n rise: any state->IDLE.
REQ-015 Each SCLK rise in CMD/DATA SHALL shift synchronized MOSI into 16-bit rx shift register LSB and increment bit counter (saturating at 16).
REQ-016 On 8th rise with R/W=1, 8-bit tx register SHALL load register[address]; MISO = tx[7]; tx shifts left on SCLK falls 9..15 only.
REQ-017 Completed frame = SS_n rise with bit counter exactly 16; write frames SHALL then write rx[7:0] to writable address.
REQ-018 Aborted frame (SS_n rise with count != 16): no write, no INT clear, no side effects.
REQ-019 Map: 0x0D INT_CTRL RW (bit1 = yaw data-ready INT enable); 0x0F WHO_AM_I RO; 0x10 CFG RW; 0x26 YAW_L RO; 0x27 YAW_H RO; unmapped reads 0x00, writes ignored; writes to RO ignored.
REQ-020 yaw_vld SHALL capture yaw_in into YAW_H:YAW_L next clk, except while a read of 0x26/0x27 is in DATA: capture deferred to the clk after SS_n rise (latest sample kept).
REQ-021 INT SHALL set on yaw capture when INT_CTRL[1]=1; clear on completed read of 0x27; set wins when simultaneous.
REQ-022 Clearing INT_CTRL[1] SHALL NOT clear a pending INT.

Reset
REQ-023 RST SHALL force: FSM IDLE, counter 0, rx/tx 0, MISO 0, INT 0, INT_CTRL 0x00, CFG 0x00, YAW 0x0000, synchronizer flops idle (SS_n=1, SCLK=1, MOSI=0).
REQ-024 RST mid-frame SHALL abort it; frame restarts only on next SS_n fall after RST release.

Configuration
REQ-025 Macro INERT_SERF_INT_EN defined: INT per REQ-021/022, INT_CTRL implemented.
REQ-026 INERT_SERF_INT_EN undefined: INT tied 0, INT_CTRL reads 0x00, writes ignored; all else unchanged.

Structure
REQ-027 Package inert_serf_pkg SHALL hold register address localparams, default WHO_AM_I, and FSM state enum.
REQ-028 Sub-module serf_sync_edge (2-flop sync + rise/fall strobes, reset-value parameter) SHALL be instantiated for SS_n and SCLK.

Verification
REQ-029 Frame 16'h8F00 -> MISO bits 7:0 = 8'h6A; INT stays 0.
REQ-030 Write 16'h1055 then read 16'h9000 -> cfg = 8'h55 after first SS_n rise; read returns 8'h55.
REQ-031 Write 16'h0D02, yaw_vld with yaw_in=16'h1234 -> INT=1; read 0xA6 returns 8'h34, INT still 1; read 0xA7 returns 8'h12, INT=0 at SS_n rise.
REQ-032 yaw_vld with 16'hBEEF during DATA of 0xA7 read -> read returns old high byte; YAW = 16'hBEEF after SS_n rise; INT set, not cleared.
REQ-033 Write 16'h10AA aborted after 12 SCLK rises -> cfg unchanged (0x00); next full frame decodes correctly.
REQ-034 RST pulse mid-read -> MISO=0, INT=0, all registers reset; next 16'h8F00 returns 8'h6A.
